// File: rtl/pow2_exp_sched.sv
// Shared-unit softmax exponent sequencer: captures N Q4.12 scores, evaluates 2^(x_i - max)
// one element per cycle, then streams results and their sum. Define POW2_SCHED_SAT_EN to saturate diff.

module pow2_approx (
    input  logic [15:0] x,
    output logic [15:0] y
);
    // Piecewise-linear 2^x: integer part is a shift, fraction f approximated as 2^f ~ 1 + f.
    logic [12:0] mant;
    logic [3:0]  rshift;
    logic [19:0] wide;

    assign mant   = {1'b1, x[11:0]};
    assign rshift = 4'd0 - x[15:12];
    assign wide   = {7'b0, mant} << x[14:12];

    always_comb begin
        y = 16'h0000;
        if (x[15]) begin
            y = {3'b000, mant >> rshift};
        end else if (wide > 20'h07FFF) begin
            y = 16'h7FFF;
        end else begin
            y = wide[15:0];
        end
    end
endmodule

module pow2_exp_sched #(
    parameter int N     = 8,
    parameter int SUM_W = 16 + $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic [SUM_W-1:0] sum_out,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXP,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]   idx;
    logic signed [15:0] max_val;
    logic signed [15:0] in_s;
    logic [15:0]        vec_mem [N];
    logic [SUM_W-1:0]   sum_acc;
    logic               done_r;
    logic               in_hs;
    logic               out_hs;
    logic               at_last;
    logic signed [16:0] diff_full;
    logic [15:0]        diff_red;
    logic [15:0]        exp_val;

    function automatic logic [15:0] reduce_diff(input logic signed [16:0] d);
`ifdef POW2_SCHED_SAT_EN
        if (d < -17'sd32768) begin
            return 16'h8000;
        end
        return 16'(d);
`else
        return 16'(d);
`endif
    endfunction

    assign in_s      = in_data;
    assign at_last   = (idx == LAST_IDX);
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_OUT);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign out_data  = out_valid ? vec_mem[idx] : 16'h0000;
    assign out_last  = out_valid && at_last;
    assign busy      = (state != S_IDLE);
    assign done      = done_r;
    assign sum_out   = sum_acc;

    // diff is never positive in normal use, so only the low end needs saturation.
    assign diff_full = {vec_mem[idx][15], vec_mem[idx]} - {max_val[15], max_val};
    assign diff_red  = reduce_diff(diff_full);

    pow2_approx u_pow2 (
        .x(diff_red),
        .y(exp_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: if (in_hs && at_last) state_nxt = S_EXP;
            S_EXP:  if (at_last) state_nxt = S_OUT;
            S_OUT:  if (out_hs && at_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            max_val <= 16'sh8000;
            sum_acc <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (start) begin
                        max_val <= 16'sh8000;
                        sum_acc <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_hs) begin
                        idx <= at_last ? '0 : idx + 1'b1;
                        if (idx == '0 || in_s > max_val) begin
                            max_val <= in_s;
                        end
                    end
                end
                S_EXP: begin
                    idx     <= at_last ? '0 : idx + 1'b1;
                    sum_acc <= sum_acc + {{(SUM_W-16){1'b0}}, exp_val};
                end
                S_OUT: begin
                    if (out_hs) begin
                        idx <= at_last ? '0 : idx + 1'b1;
                        if (at_last) begin
                            done_r <= 1'b1;
                        end
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

    // Score buffer is rewritten in place with the exponentials.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            vec_mem[idx] <= in_data;
        end else if (state == S_EXP) begin
            vec_mem[idx] <= exp_val;
        end
    end
endmodule

// File: tb/tb_pow2_exp_sched.sv
// Scoreboard bench for pow2_exp_sched (N=4): random and directed vectors against a real-valued reference.
module tb_pow2_exp_sched;
    localparam int N     = 4;
    localparam int SUM_W = 16 + $clog2(N);

    typedef logic [15:0] vec_t [N];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = 16'h0000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic             out_last;
    logic [SUM_W-1:0] sum_out;
    logic             busy;
    logic             done;

    pow2_exp_sched #(.N(N), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sum_out(sum_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0]      exp_data_q[$];
    logic             exp_last_q[$];
    logic [SUM_W-1:0] exp_sum_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: 2^x with the fractional part linearised, evaluated in real arithmetic.
    function automatic int pow2_ref(input int x);
        int  e;
        real m, r;
        e = (x >= 0) ? x / 4096 : -((-x + 4095) / 4096);
        m = 1.0 + real'(x - e * 4096) / 4096.0;
        r = m * (2.0 ** e) * 4096.0;
        if (r > 32767.0) return 32767;
        return int'($floor(r));
    endfunction

    function automatic logic [SUM_W-1:0] push_expected(input vec_t v);
        logic signed [15:0] s;
        int mx, d, r, sum;
        logic [31:0] dw;
        mx = -32768;
        for (int i = 0; i < N; i++) begin
            s = v[i];
            if (int'(s) > mx) mx = int'(s);
        end
        sum = 0;
        for (int i = 0; i < N; i++) begin
            s = v[i];
            d = int'(s) - mx;
`ifdef POW2_SCHED_SAT_EN
            if (d < -32768) d = -32768;
`else
            dw = d;
            s  = dw[15:0];
            d  = int'(s);
`endif
            r = pow2_ref(d);
            exp_data_q.push_back(r[15:0]);
            exp_last_q.push_back(i == N - 1);
            sum += r;
        end
        exp_sum_q.push_back(SUM_W'(sum));
        return SUM_W'(sum);
    endfunction

    // Monitor: pops and compares on every output handshake, watches hold and done timing.
    int          hs_in_vec = 0;
    int          done_cnt = 0;
    logic        stalled = 1'b0;
    logic [15:0] held_data = 16'h0;
    logic        held_last = 1'b0;
    logic        last_hs_prev = 1'b0;
    logic [15:0] m_d;
    logic        m_l;

    always @(negedge clk) begin
        if (done || last_hs_prev) check("done_pulse", 32'(done), 32'(last_hs_prev));
        if (done) done_cnt++;
        last_hs_prev = 1'b0;
        if (out_valid) begin
            if (stalled) begin
                check("hold_data", 32'(out_data), 32'(held_data));
                check("hold_last", 32'(out_last), 32'(held_last));
            end
            if (out_ready) begin
                if (exp_data_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", out_data);
                end else begin
                    m_d = exp_data_q.pop_front();
                    m_l = exp_last_q.pop_front();
                    check("out_data", 32'(out_data), 32'(m_d));
                    check("out_last", 32'(out_last), 32'(m_l));
                    check("sum_out", 32'(sum_out), 32'(exp_sum_q[0]));
                    if (m_l) void'(exp_sum_q.pop_front());
                end
                hs_in_vec++;
                stalled = 1'b0;
                if (out_last) last_hs_prev = 1'b1;
            end else begin
                stalled   = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // out_ready policy: 0 always ready, 1 random, 2 three-cycle stall on element 1.
    int bp_mode = 0;
    int held = 0;
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid && hs_in_vec == 1 && held < 3) begin
                    out_ready = 1'b0;
                    held++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic load_inputs(input vec_t v, input bit gaps, input bit start_mid);
        bit hs, ok;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_data  = v[i];
            if (start_mid && i == 1) start = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk); hs = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (hs) begin ok = 1'b1; break; end
            end
            if (!ok) check("in_hs_timeout", 32'(ok), 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input bit gaps, input int mode, input bit start_mid);
        logic [SUM_W-1:0] esum;
        int  d0, lat;
        bit  pulsed, ok;
        esum = push_expected(v);
        bp_mode   = mode;
        held      = 0;
        hs_in_vec = 0;
        d0 = done_cnt;
        load_inputs(v, gaps, start_mid);
        lat = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("latency", 32'(lat), 32'(N + 1));
        pulsed = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (start_mid && !pulsed && out_valid && !out_last) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        if (!ok) check("done_timeout", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("sum_hold", 32'(sum_out), 32'(esum));
        check("queue_drained", 32'(exp_data_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_sum_out"}, 32'(sum_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    vec_t v;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_vec(v, 1'b0, 0, 1'b0);
        v = '{16'h1000, 16'h0000, 16'hF000, 16'h2000};
        run_vec(v, 1'b0, 0, 1'b0);
        run_vec(v, 1'b0, 2, 1'b0);
        run_vec(v, 1'b1, 0, 1'b0);
        v = '{16'h7000, 16'h9000, 16'h7000, 16'h7000};
        run_vec(v, 1'b0, 0, 1'b0);
        v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_vec(v, 1'b0, 1, 1'b1);

        // Abort mid-EXP, then confirm a clean restart.
        bp_mode = 0;
        for (int i = 0; i < N; i++) v[i] = 16'($urandom);
        load_inputs(v, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (4) @(negedge clk);
        check("abort_in_ready_low", 32'(in_ready), 32'd0);
        v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_vec(v, 1'b0, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k % 2 == 0) v[i] = 16'($urandom);
                else v[i] = 16'($urandom_range(0, 16'h3FFF) - 16'h1FFF);
            end
            run_vec(v, 1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pow2_exp_sched.md
# pow2_exp_sched

Sequencer that shares one combinational `pow2_approx` instance (Q4.12 in, Q4.12 out) across an N-element vector for the non-pipelined softmax path. It captures N signed Q4.12 scores, tracks the running maximum, evaluates 2^(x_i − max) one element per cycle through the shared unit, and accumulates the sum. It then streams the N exponentials plus the sum to the normalisation/divide stage over a valid/ready handshake.

## Interface
- `N`, default 8: vector length, 2..64.
- `SUM_W`, default 16+$clog2(N): sum width, unsigned Q(SUM_W−12).12.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a new vector. Honoured only in IDLE.
- `in_valid` input 1: input score valid.
- `in_ready` output 1: block accepts a score; high only in LOAD.
- `in_data` input 16: signed Q4.12 score.
- `out_valid` output 1: exponential valid; high only in OUT.
- `out_ready` input 1: downstream accepts the exponential.
- `out_data` output 16: Q4.12 value of 2^(x_i − max).
- `out_last` output 1: high with element N−1.
- `sum_out` output SUM_W: Σ out_data. Stable from OUT entry until the next `start` is accepted.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse after the last output handshake.

## Operation
- States: IDLE, LOAD, EXP, OUT.
- IDLE:
  - On `start` → LOAD.
  - Clears idx, max and sum in the same edge.
- LOAD:
  - On each `in_valid && in_ready`, write buf[idx] = in_data and increment idx.
  - max = in_data for idx 0; otherwise the signed maximum of max and in_data.
  - On the handshake with idx = N−1 → EXP, idx = 0.
  - Gaps in `in_valid` stall without effect.
- EXP, one element per cycle:
  - diff = buf[idx] − max, computed 17-bit signed, then reduced to 16 bits (see Configuration).
  - diff is fed to the shared `pow2_approx`; its result overwrites buf[idx]; sum += result, zero-extended to SUM_W.
  - After idx = N−1 → OUT, idx = 0.
  - diff ≤ 0 always holds, so each result is ≤ 0x1000 and sum cannot overflow SUM_W.
- OUT:
  - out_data = buf[idx]; out_last = (idx == N−1).
  - On `out_valid && out_ready`, increment idx.
  - On the last handshake → IDLE with `done` = 1 for one cycle.
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored.
- Reset, including mid-vector:
  - Next state is IDLE; buffered data is discarded.
  - in_ready=0, out_valid=0, out_data=0, out_last=0, sum_out=0, busy=0, done=0, max=0x8000, idx=0.

## Timing
- `start` sampled at edge t → `in_ready` = 1 from cycle t+1.
- Last input handshake at edge c → EXP occupies cycles c+1..c+N → `out_valid` rises in cycle c+N+1.
- Input-to-first-output latency: N+1 cycles.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- With `out_ready` tied high, OUT lasts exactly N cycles.
- `done` is asserted in the cycle after the final output handshake.
- `start` is accepted in that same cycle, since the state is already IDLE.
- Minimum vector period with no stalls: 1 + N + N + N cycles.
- `pow2_approx` is combinational, so there is no extra pipeline stage; its result is registered into buf.

## Configuration
- `POW2_SCHED_SAT_EN` defined:
  - diff < −8.0 (17-bit value < −32768) saturates to 0x8000.
  - Far-below-max elements yield pow2(−8.0) = 0x0010.
- `POW2_SCHED_SAT_EN` undefined:
  - diff is truncated to its low 16 bits (two's-complement wrap).
  - Smaller area; valid only when the input score spread is < 8.0.

## Test plan
- N=4, inputs 0x0000 ×4 → out_data 0x1000 ×4, out_last on the 4th only, sum_out 0x4000, one `done` pulse.
- N=4, inputs {0x1000, 0x0000, 0xF000, 0x2000}:
  - Required response: max 0x2000; outputs {0x0800, 0x0400, 0x0200, 0x1000}; sum_out 0x1E00; first `out_valid` 5 cycles after the last input handshake.
- N=2, inputs {0x7000, 0x9000}:
  - With `POW2_SCHED_SAT_EN`: outputs {0x1000, 0x0010}, sum 0x1010.
  - Without it: diff wraps to +2.0 and the second output equals pow2_approx(0x2000).
- Backpressure: `out_ready` low for 3 cycles on element 1 → out_data and out_last held, no element skipped or duplicated. Also `in_valid` gaps in LOAD → same results as the no-gap run.
- `rst` asserted for 1 cycle during EXP:
  - Next cycle: all outputs at reset values; `in_ready` stays 0 until a new `start`.
  - A subsequent all-zero vector gives sum 0x4000, with no residue from the aborted run.
- `start` pulsed during LOAD and during OUT → ignored: idx, max and the output sequence are unchanged, and exactly one `done` pulse occurs.
